// File: rtl/alu_exec_stage.sv
// ALU execute stage: registers the result of a decoded ALU op behind a valid/ready handshake.
// Optional iterative shift-add multiply for code 011 is enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b110;
    localparam logic [2:0] FN_SLT = 3'b111;
    localparam logic [2:0] FN_NOR = 3'b100;
    localparam logic [2:0] FN_XOR = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_CALC} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             start_mul;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] b_neg;
    logic [WIDTH-1:0] diff;
    logic             slt;

    assign accept = in_valid && in_ready;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [2:0]   FN_MUL = 3'b011;
    localparam int unsigned  CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;
    logic             mul_done;

    assign start_mul = accept && (alu_funct == FN_MUL);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done  = (state_q == S_CALC) && (cnt_q == CNT_LAST);
`else
    assign start_mul = 1'b0;
`endif

    // Single-cycle ALU functions; SUB adds the two's complement so its sign feeds overflow
    always_comb begin
        sum     = op_a + op_b;
        b_neg   = ~op_b + WIDTH'(1);
        diff    = op_a + b_neg;
        slt     = $signed(op_a) < $signed(op_b);
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_funct)
            FN_AND: alu_res = op_a & op_b;
            FN_OR:  alu_res = op_a | op_b;
            FN_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            FN_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            FN_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            FN_NOR: alu_res = ~(op_a | op_b);
            FN_XOR: alu_res = op_a ^ op_b;
`ifdef ALU_EXEC_MUL_EN
            FN_MUL: alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = start_mul ? S_CALC : S_HOLD;
            S_HOLD: begin
                if (out_ready) state_d = accept ? (start_mul ? S_CALC : S_HOLD) : S_IDLE;
            end
`ifdef ALU_EXEC_MUL_EN
            S_CALC: if (mul_done) state_d = S_HOLD;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
        out_valid = (state_q == S_HOLD);
`ifdef ALU_EXEC_MUL_EN
        busy      = (state_q == S_CALC);
`else
        busy      = 1'b0;
`endif
        result    = result_q;
        zero      = zero_q;
        overflow  = overflow_q;
        illegal   = illegal_q;
    end

    // Result/flag next values; the register holds its value unless a result is loaded
    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        if (accept && !start_mul) begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ovf;
            illegal_d  = alu_ill;
        end
`ifdef ALU_EXEC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_mul) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_CALC) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_done) begin
                result_d   = acc_step;
                zero_d     = (acc_step == '0);
                overflow_d = 1'b0;
                illegal_d  = 1'b0;
            end
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (WIDTH=32); MUL checks follow ALU_EXEC_MUL_EN.
module tb_alu_exec_stage;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;

    int checks;
    int failures;

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_funct (alu_funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid  = 1'b1;
        alu_funct = f;
        op_a      = a;
        op_b      = b;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_funct = 3'b000;
        op_a      = '0;
        op_b      = '0;

        repeat (2) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({zero, overflow, illegal, busy}), 64'd0);
        reset = 1'b0;
        step();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // ADD overflow
        issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        chk("add_result", 64'(result), 64'h8000_0000);
        chk("add_ovf", 64'(overflow), 64'd1);
        chk("add_zero", 64'(zero), 64'd0);
        chk("add_valid", 64'(out_valid), 64'd1);

        // SUB to zero, accepted from HOLD
        issue(3'b110, 32'd5, 32'd5);
        step();
        chk("sub_result", 64'(result), 64'd0);
        chk("sub_zero", 64'(zero), 64'd1);
        chk("sub_ovf", 64'(overflow), 64'd0);

        issue(3'b111, 32'h8000_0000, 32'd1);
        step();
        chk("slt_neg_pos", 64'(result), 64'd1);
        issue(3'b111, 32'd1, 32'h8000_0000);
        step();
        chk("slt_pos_neg", 64'(result), 64'd0);
        chk("slt_zero", 64'(zero), 64'd1);
        issue(3'b100, 32'd0, 32'd0);
        step();
        chk("nor_result", 64'(result), 64'hFFFF_FFFF);
        issue(3'b101, 32'hF0F0_1234, 32'h0FF0_1234);
        step();
        chk("xor_result", 64'(result), 64'hFF00_0000);
        issue(3'b001, 32'hA000_0005, 32'h0500_000A);
        step();
        chk("or_result", 64'(result), 64'hA500_000F);

        // Drain to IDLE; result register keeps value
        in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_keep", 64'(result), 64'hA500_000F);

        // Back-to-back stream of ADDs
        for (int i = 0; i < 4; i++) begin
            issue(3'b010, WIDTH'(i), 32'd100);
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_result", 64'(result), 64'(100 + i));
        end

        // Stall for 3 cycles with a pending request whose operands keep changing
        out_ready = 1'b0;
        issue(3'b010, 32'd4, 32'd100);
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            op_a = WIDTH'(50 + i);
            step();
            chk("stall_result", 64'(result), 64'd103);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        op_a = 32'd4;
        out_ready = 1'b1;
        step();
        chk("resume_result", 64'(result), 64'd104);
        issue(3'b010, 32'd5, 32'd100);
        step();
        chk("resume_next", 64'(result), 64'd105);
        in_valid = 1'b0;
        step();
        chk("resume_drain", 64'(out_valid), 64'd0);

        // Reset asserted during HOLD
        out_ready = 1'b0;
        issue(3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F);
        step();
        in_valid = 1'b0;
        chk("and_result", 64'(result), 64'h0F0F_0000);
        reset = 1'b1;
        step();
        chk("hold_rst_valid", 64'(out_valid), 64'd0);
        chk("hold_rst_result", 64'(result), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();

`ifndef ALU_EXEC_MUL_EN
        issue(3'b011, 32'd7, 32'd6);
        step();
        in_valid = 1'b0;
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_result", 64'(result), 64'd0);
        chk("ill_valid", 64'(out_valid), 64'd1);
        chk("ill_busy", 64'(busy), 64'd0);
        step();
`else
        issue(3'b011, 32'd7, 32'd6);
        step();
        in_valid = 1'b0;
        chk("mul_busy_start", 64'({busy, in_ready, out_valid}), 64'b100);
        for (int k = 1; k < 32; k++) begin
            step();
            chk("mul_busy", 64'({busy, in_ready, out_valid}), 64'b100);
        end
        step();
        chk("mul_result", 64'(result), 64'd42);
        chk("mul_done", 64'({busy, out_valid, illegal, overflow}), 64'b0100);
        step();

        // Reset at cycle 10 of a MUL, then ADD 2+3
        issue(3'b011, 32'd7, 32'd6);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("mul_mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mul_rst_state", 64'({busy, out_valid}), 64'b00);
        issue(3'b010, 32'd2, 32'd3);
        step();
        in_valid = 1'b0;
        chk("post_rst_add", 64'(result), 64'd5);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
